// File: rtl/zext_ram_pkg.sv
// Shared ExtRAM arbiter types: bus widths, controller handshake bit indices, FSM states.
// Purely declarative; no latency or backpressure of its own.
package zext_ram_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  localparam int REQ_RD = 0;
  localparam int REQ_WR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [1:0]  bank,
                                                  input logic [11:0] row,
                                                  input logic [7:0]  col);
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/zext_ram_rr_pick.sv
// Combinational round-robin picker: first pending port after last_i, as a one-hot vector.
// Zero latency; no backpressure, the caller registers the result.
module zext_ram_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend_i,
  input  logic [LW-1:0]      last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               vld_o
);

  logic [LW-1:0] idx;

  always_comb begin
    pick_o = '0;
    vld_o  = 1'b0;
    idx    = '0;
    // Walk last+1 .. last+NUM_REQ so last itself has the lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = LW'((int'(last_i) + i) % NUM_REQ);
      if (!vld_o && pend_i[idx]) begin
        pick_o[idx] = 1'b1;
        vld_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zext_ram_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one ExtRAM controller port.
// Request->oRequest 1 cycle, iDone->oReqDone 1 cycle; requesters wait on done, stuck ops abort after TIMEOUT.
module zext_ram_arbiter
  import zext_ram_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 100_000
) (
  input  logic                      iClk,
  input  logic                      iRst_N,
  input  logic [NUM_REQ-1:0]        iReqRd,
  input  logic [NUM_REQ-1:0]        iReqWr,
  input  logic [NUM_REQ*ADDR_W-1:0] iReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] iReqWrData,
  output logic [NUM_REQ-1:0]        oReqDone,
  output logic                      oReqErr,
  output logic [DATA_W-1:0]         oReqRdData,
  output logic [NUM_REQ-1:0]        oGrant,
  output logic [ADDR_W-1:0]         oRAMAddr,
  output logic [DATA_W-1:0]         oWrData,
  output logic [1:0]                oRequest,
  input  logic [DATA_W-1:0]         iRdData,
  input  logic [1:0]                iDone
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAST_RST  = LW'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [LW-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [1:0]          req_q, req_d;
  logic                op_wr_q, op_wr_d;
  logic                conflict_q, conflict_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic [NUM_REQ-1:0]  pend;
  logic [NUM_REQ-1:0]  pick;
  logic                pick_vld;
  logic [LW-1:0]       pick_idx;
  logic                done_hit;

  assign pend = iReqRd | iReqWr;

  zext_ram_rr_pick #(.NUM_REQ(NUM_REQ), .LW(LW)) u_pick (
    .pend_i (pend),
    .last_i (last_q),
    .pick_o (pick),
    .vld_o  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pick_idx = LW'(k);
    end
  end

  // Only the done bit matching the issued op counts; the other is ignored.
  assign done_hit = op_wr_q ? iDone[REQ_WR] : iDone[REQ_RD];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = 1'b0;
    rdat_d     = rdat_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    req_d      = req_q;
    op_wr_d    = op_wr_q;
    conflict_d = conflict_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d    = pick;
          last_d     = pick_idx;
          addr_d     = iReqAddr[pick_idx*ADDR_W +: ADDR_W];
          wdat_d     = iReqWrData[pick_idx*DATA_W +: DATA_W];
          op_wr_d    = iReqWr[pick_idx];
          conflict_d = iReqWr[pick_idx] & iReqRd[pick_idx];
          req_d      = iReqWr[pick_idx] ? 2'b10 : 2'b01;
          timer_d    = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (done_hit) begin
          req_d   = 2'b00;
          done_d  = grant_q;
          err_d   = conflict_q;
          if (!op_wr_q) rdat_d = iRdData;
          state_d = GAP;
        end else if (timer_q == TIMER_MAX) begin
          req_d   = 2'b00;
          done_d  = grant_q;
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (iDone == 2'b00) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_N) begin
      state_q    <= IDLE;
      last_q     <= LAST_RST;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      req_q      <= 2'b00;
      op_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      req_q      <= req_d;
      op_wr_q    <= op_wr_d;
      conflict_q <= conflict_d;
      timer_q    <= timer_d;
    end
  end

  assign oReqDone   = done_q;
  assign oReqErr    = err_q;
  assign oReqRdData = rdat_q;
  assign oGrant     = grant_q;
  assign oRAMAddr   = addr_q;
  assign oWrData    = wdat_q;
  assign oRequest   = req_q;

endmodule

// File: tb/tb_zext_ram_arbiter.sv
// Directed bench for zext_ram_arbiter with a behavioural controller and a done scoreboard.
module tb_zext_ram_arbiter;
  import zext_ram_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic              clk;
  logic              iRst_N;
  logic [N-1:0]      iReqRd, iReqWr;
  logic [N*22-1:0]   iReqAddr;
  logic [N*32-1:0]   iReqWrData;
  logic [N-1:0]      oReqDone;
  logic              oReqErr;
  logic [31:0]       oReqRdData;
  logic [N-1:0]      oGrant;
  logic [21:0]       oRAMAddr;
  logic [31:0]       oWrData;
  logic [1:0]        oRequest;
  logic [31:0]       iRdData;
  logic [1:0]        iDone;

  zext_ram_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .iClk(clk), .iRst_N(iRst_N), .iReqRd(iReqRd), .iReqWr(iReqWr),
    .iReqAddr(iReqAddr), .iReqWrData(iReqWrData), .oReqDone(oReqDone),
    .oReqErr(oReqErr), .oReqRdData(oReqRdData), .oGrant(oGrant),
    .oRAMAddr(oRAMAddr), .oWrData(oWrData), .oRequest(oRequest),
    .iRdData(iRdData), .iDone(iDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        err;
    logic        is_rd;
    logic [21:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = '0;
  int          checks = 0;
  int          errors = 0;

  // Behavioural controller: answers `ctl_lat` cycles after oRequest rises, never if negative.
  int   ctl_lat  = 5;
  int   req_cnt  = 0;
  int   last_len = 0;
  logic saw_read = 1'b0;

  always @(negedge clk) begin
    if (oRequest != 2'b00) begin
      if (oRequest[0]) saw_read = 1'b1;
      if (ctl_lat >= 0 && req_cnt >= ctl_lat) iDone = oRequest;
      else iDone = 2'b00;
      req_cnt = req_cnt + 1;
    end else begin
      if (req_cnt != 0) last_len = req_cnt;
      req_cnt = 0;
      iDone   = 2'b00;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int k, input logic rd, input logic wr,
                          input logic [21:0] a, input logic [31:0] d);
    iReqRd[k]          = rd;
    iReqWr[k]          = wr;
    iReqAddr[k*22+:22] = a;
    iReqWrData[k*32+:32] = d;
  endtask

  task automatic push(input int p, input logic e, input logic r,
                      input logic [21:0] a, input logic [31:0] d);
    exp_t x;
    x.port = p; x.err = e; x.is_rd = r; x.addr = a; x.rdata = d;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    logic [N-1:0] oh;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (oReqDone == '0 && n < 200);
    checks++;
    assert (oReqDone != '0)
    else begin
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done_within_200", tag);
    end
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL %s_sb_empty observed=done expected=no_done", tag);
    end
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      oh = '0;
      oh[e.port] = 1'b1;
      if (e.is_rd) model_rdata = e.rdata;
      chk({tag, "_done"},  oReqDone,   oh);
      chk({tag, "_grant"}, oGrant,     oh);
      chk({tag, "_err"},   oReqErr,    e.err);
      chk({tag, "_addr"},  oRAMAddr,   e.addr);
      chk({tag, "_rdata"}, oReqRdData, model_rdata);
      chk({tag, "_reqlo"}, oRequest,   2'b00);
    end
  endtask

  logic [21:0] a1, a3, a0;
  int          prev_cyc;

  initial begin
    iRst_N = 1'b0; iReqRd = '0; iReqWr = '0; iReqAddr = '0; iReqWrData = '0;
    iRdData = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_request", oRequest, 2'b00);
    chk("rst_grant",   oGrant,   4'b0000);
    chk("rst_done",    oReqDone, 4'b0000);
    chk("rst_err",     oReqErr,  1'b0);
    chk("rst_rdata",   oReqRdData, 32'h0);
    chk("rst_addr",    oRAMAddr, 22'h0);
    iRst_N = 1'b1;

    // Port 1 write, controller answers after 5 cycles.
    a1 = pack_addr(2'b00, 12'd0, 8'h01);
    set_port(1, 1'b0, 1'b1, a1, 32'h19870901);
    push(1, 1'b0, 1'b0, a1, 32'h0);
    @(posedge clk); #1;
    chk("p1_req_rise", oRequest, 2'b10);
    chk("p1_addr_out", oRAMAddr, a1);
    chk("p1_wdat_out", oWrData,  32'h19870901);
    chk("p1_grant",    oGrant,   4'b0010);
    wait_done("p1_wr");
    set_port(1, 1'b0, 1'b0, a1, 32'h0);
    @(posedge clk); #1;
    chk("p1_done_single", oReqDone, 4'b0000);
    chk("p1_req_len",     last_len, 6);

    // Port 2 reads it back.
    iRdData = 32'h19870901;
    set_port(2, 1'b1, 1'b0, a1, 32'h0);
    push(2, 1'b0, 1'b1, a1, 32'h19870901);
    @(posedge clk); #1;
    chk("p2_req_rise", oRequest, 2'b01);
    wait_done("p2_rd");
    set_port(2, 1'b0, 1'b0, a1, 32'h0);
    @(posedge clk); #1;
    chk("p2_req_after", oRequest, 2'b00);

    // Controller never answers port 3; port 0 waits behind it.
    iRdData = 32'hDEADBEEF;
    ctl_lat = -1;
    a3 = pack_addr(2'b11, 12'h123, 8'h45);
    a0 = pack_addr(2'b01, 12'h0AA, 8'h10);
    set_port(3, 1'b0, 1'b1, a3, 32'h33333333);
    set_port(0, 1'b0, 1'b1, a0, 32'h00000000);
    push(3, 1'b1, 1'b0, a3, 32'h0);
    push(0, 1'b0, 1'b0, a0, 32'h0);
    @(posedge clk); #1;
    chk("p3_req_rise", oRequest, 2'b10);
    chk("p3_grant",    oGrant,   4'b1000);
    wait_done("p3_abort");
    ctl_lat = 2;
    set_port(3, 1'b0, 1'b0, a3, 32'h0);
    @(posedge clk); #1;
    chk("p3_req_len", last_len, TO);
    wait_done("p0_after_abort");
    set_port(0, 1'b0, 1'b0, a0, 32'h0);
    @(posedge clk); #1;

    // Read and write together on port 0: write only, flagged.
    saw_read = 1'b0;
    set_port(0, 1'b1, 1'b1, a1, 32'hCAFEF00D);
    push(0, 1'b1, 1'b0, a1, 32'h0);
    @(posedge clk); #1;
    chk("rdwr_req", oRequest, 2'b10);
    wait_done("rdwr");
    set_port(0, 1'b0, 1'b0, a1, 32'h0);
    @(posedge clk); #1;
    chk("rdwr_no_read", saw_read, 1'b0);

    // Reset in the middle of a stuck transaction.
    ctl_lat = -1;
    set_port(1, 1'b0, 1'b1, a3, 32'h11111111);
    @(posedge clk); #1;
    chk("mid_busy_req", oRequest, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    iRst_N = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req",   oRequest, 2'b00);
    chk("mid_rst_grant", oGrant,   4'b0000);
    chk("mid_rst_done",  oReqDone, 4'b0000);
    model_rdata = 32'h0;
    chk("mid_rst_rdata", oReqRdData, 32'h0);

    // All ports pending continuously, latency 2: strict rotation from port 0.
    ctl_lat = 2;
    iRdData = 32'h0BADF00D;
    for (int k = 0; k < N; k++)
      set_port(k, (k == 2), (k != 2), pack_addr(2'(k), 12'(k * 3), 8'(k + 1)), 32'(k * 32'h01010101));
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        push(k, 1'b0, (k == 2), pack_addr(2'(k), 12'(k * 3), 8'(k + 1)), 32'h0BADF00D);
    @(posedge clk); #1;
    iRst_N = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 2 * N; i++) begin
      wait_done($sformatf("rr%0d", i));
      if (i == 2 * N - 1) begin
        iReqRd = '0;
        iReqWr = '0;
      end
      if (i > 0) chk($sformatf("rr%0d_spacing", i), 64'(cyc - prev_cyc), 64'd5);
      prev_cyc = cyc;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("end_idle_req",   oRequest, 2'b00);
    chk("end_idle_grant", oGrant,   4'b0000);
    chk("end_sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
